dcpu_bus_fabric: RTL and testbench

Parametrised single-master bus fabric for the dcpu SoC. It sits between the `dcpu` core and N memory-mapped slaves (UART, RAM, future peripherals) and replaces hand-written top-level chip-select and data/ack muxing. It provides:
- mask/base address decode with fixed priority;
- registered slave selects;
- an error response for unmapped addresses;
- an optional ack timeout;
- slave interrupt aggregation into the CPU `i_irq`.

---
 rtl/dcpu_bus_pkg.sv | 19 +
 rtl/dcpu_bus_if.sv | 16 +
 rtl/dcpu_bus_decode.sv | 27 ++
 rtl/dcpu_bus_fabric.sv | 128 ++++++++++++
 tb/tb_dcpu_bus_fabric.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcpu_bus_pkg.sv
// Shared state encoding, default error read-back value and slot-slice helper
// for the dcpu bus fabric.
package dcpu_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_RESP   = 2'd2;
  localparam state_t S_DONE   = 2'd3;

  localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;

  // LSB position of slot 'slot' within a flattened vector of 'width'-bit fields.
  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned width);
    return slot * width;
  endfunction

endpackage

// File: rtl/dcpu_bus_if.sv
// CPU-side request/response bus of the dcpu fabric; master = core, slave = fabric.
interface dcpu_bus_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              i_cs;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_dat;
  logic [DATA_W-1:0] o_dat;
  logic              o_ack;
  logic              o_err;

  modport master (output i_cs, i_we, i_addr, i_dat, input o_dat, o_ack, o_err);
  modport slave  (input i_cs, i_we, i_addr, i_dat, output o_dat, o_ack, o_err);
endinterface

// File: rtl/dcpu_bus_decode.sv
// Combinational mask/base address decoder: one-hot hit, lowest slot index wins.
module dcpu_bus_decode
  import dcpu_bus_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = 2,
  parameter int unsigned                  ADDR_W     = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic                  none
);

  always_comb begin
    hit  = '0;
    none = 1'b1;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (none && ((addr & SLAVE_MASK[slot_lsb(k, ADDR_W) +: ADDR_W])
                   == SLAVE_BASE[slot_lsb(k, ADDR_W) +: ADDR_W])) begin
        hit[k] = 1'b1;
        none   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dcpu_bus_fabric.sv
// Single-master bus fabric: decode, registered slave selects, error response, IRQ OR.
// Define DCPU_BUS_TIMEOUT_EN to enable the TIMEOUT_CYCLES ack timeout in ACCESS.
module dcpu_bus_fabric
  import dcpu_bus_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES     = 2,
  parameter int unsigned                  ADDR_W         = 16,
  parameter int unsigned                  DATA_W         = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {16'hFFFE, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {16'hFFFE, 16'h0000},
  parameter int unsigned                  TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0]            ERR_DATA       = DATA_W'(DEF_ERR_DATA),
  parameter logic [NUM_SLAVES-1:0]        IRQ_MASK       = '1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  dcpu_bus_if.slave                    bus,
  output logic [NUM_SLAVES-1:0]        o_s_cs,
  output logic                         o_s_we,
  output logic [ADDR_W-1:0]            o_s_addr,
  output logic [DATA_W-1:0]            o_s_dat,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_s_dat,
  input  logic [NUM_SLAVES-1:0]        i_s_ack,
  input  logic [NUM_SLAVES-1:0]        i_s_irq,
  output logic                         o_irq
);

  state_t                  state;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic                    err_q;
  logic [DATA_W-1:0]       dat_q;
  logic                    irq_q;
  logic [NUM_SLAVES-1:0]   dec_hit;
  logic                    dec_none;
  logic                    sel_ack;
  logic [DATA_W-1:0]       sel_dat;
`ifdef DCPU_BUS_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0]              tmo_cnt;
`endif

  dcpu_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr (bus.i_addr),
    .hit  (dec_hit),
    .none (dec_none)
  );

  // Only the latched slave's ack/data matter; others are masked off here.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q[k]) begin
        sel_ack = i_s_ack[k];
        sel_dat = i_s_dat[slot_lsb(k, DATA_W) +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
`ifdef DCPU_BUS_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      irq_q <= |(i_s_irq & IRQ_MASK);
      case (state)
        S_IDLE: begin
          if (bus.i_cs) begin
            if (dec_none) begin
              err_q <= 1'b1;
              dat_q <= ERR_DATA;
              state <= S_RESP;
            end else begin
              sel_q   <= dec_hit;
`ifdef DCPU_BUS_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
              state   <= S_ACCESS;
            end
          end
        end
        // Priority: selected ack, then master abort, then timeout.
        S_ACCESS: begin
          if (sel_ack) begin
            err_q <= 1'b0;
            dat_q <= sel_dat;
            state <= S_RESP;
          end else if (!bus.i_cs) begin
            state <= S_IDLE;
          end
`ifdef DCPU_BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            dat_q <= ERR_DATA;
            state <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
`endif
        end
        S_RESP:  state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_s_cs    = (state == S_ACCESS) ? sel_q : '0;
  assign o_s_we    = (state == S_ACCESS) & bus.i_we;
  assign o_s_addr  = bus.i_addr;
  assign o_s_dat   = bus.i_dat;
  assign bus.o_ack = (state == S_RESP);
  assign bus.o_err = (state == S_RESP) & err_q;
  assign bus.o_dat = dat_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_dcpu_bus_fabric.sv
// Self-checking bench for dcpu_bus_fabric: directed scenarios plus randomized
// transactions compared against a spec-level address-map/latency model.
module tb_dcpu_bus_fabric;

  localparam int unsigned TMO  = 8;
  localparam logic [15:0] ERRV = 16'hDEAD;
`ifdef DCPU_BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcpu_bus_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  logic [1:0]  s_cs;
  logic        s_we;
  logic [15:0] s_addr, s_dat;
  logic [31:0] s_rdat;
  logic [1:0]  s_ack, s_irq;
  logic        irq;

  // Slot 0: UART at 0xFFFE/0xFFFF; slot 1: RAM at 0x0000-0x3FFF; rest unmapped.
  dcpu_bus_fabric #(
    .NUM_SLAVES     (2),
    .ADDR_W         (16),
    .DATA_W         (16),
    .SLAVE_BASE     ({16'h0000, 16'hFFFE}),
    .SLAVE_MASK     ({16'hC000, 16'hFFFE}),
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (16'hDEAD),
    .IRQ_MASK       (2'b10)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .bus      (bus),
    .o_s_cs   (s_cs),
    .o_s_we   (s_we),
    .o_s_addr (s_addr),
    .o_s_dat  (s_dat),
    .i_s_dat  (s_rdat),
    .i_s_ack  (s_ack),
    .i_s_irq  (s_irq),
    .o_irq    (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_base [2] = '{16'hFFFE, 16'h0000};
  logic [15:0] m_mask [2] = '{16'hFFFE, 16'hC000};

  function automatic int model_slot(input logic [15:0] addr);
    for (int k = 0; k < 2; k++)
      if ((addr & m_mask[k]) == m_base[k]) return k;
    return -1;
  endfunction

  function automatic void model_txn(input logic [15:0] addr, input logic we, input int ack_k,
      input logic [15:0] rdat, output int slot, output int e_ack, output logic e_err,
      output logic [15:0] e_dat, output logic [63:0] e_cs, output logic [31:0] e_we);
    int last;
    slot = model_slot(addr);
    e_cs = '0;
    e_we = '0;
    if (slot < 0) begin
      e_ack = 1; e_err = 1'b1; e_dat = ERRV;
      return;
    end
    if (TMO_EN && (ack_k == 0 || ack_k > int'(TMO))) begin
      last = TMO; e_err = 1'b1; e_dat = ERRV;
    end else begin
      last = ack_k; e_err = 1'b0; e_dat = rdat;
    end
    e_ack = last + 1;
    for (int c = 1; c <= last; c++) begin
      e_cs[2*c +: 2] = 2'b01 << slot;
      e_we[c] = we;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction from IDLE; the responder acks slot 'slot' in cycle ack_k.
  task automatic run_txn(input logic [15:0] addr, input logic we, input logic [15:0] wdat,
      input int slot, input int ack_k, input logic [15:0] rdat, input bit noise,
      output int ack_cyc, output logic err, output logic [15:0] dat,
      output logic [63:0] cs_tr, output logic [31:0] we_tr, output logic ack_after);
    ack_cyc = 0; err = 1'b0; dat = '0; cs_tr = '0; we_tr = '0;
    bus.i_addr = addr; bus.i_we = we; bus.i_dat = wdat; bus.i_cs = 1'b1;
    s_ack = '0;
    for (int c = 1; c < 32; c++) begin
      tick();
      cs_tr[2*c +: 2] = s_cs;
      we_tr[c] = s_we;
      if (bus.o_ack) begin
        ack_cyc = c; err = bus.o_err; dat = bus.o_dat;
        break;
      end
      s_rdat = $urandom;
      s_ack  = noise ? 2'($urandom) : 2'b00;
      if (slot >= 0) s_ack[slot] = (c == ack_k);
      if (slot >= 0 && c == ack_k) s_rdat[16*slot +: 16] = rdat;
    end
    bus.i_cs = 1'b0;
    s_ack = '0;
    tick();
    ack_after = bus.o_ack;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_cs = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_dat = '0;
    s_rdat = '0; s_ack = '0; s_irq = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_ack, bus.o_err, bus.o_dat, s_cs, s_we, irq} !== 22'd0)
      $display("FAIL reset_outputs: got %h required 0", {bus.o_ack, bus.o_err, bus.o_dat, s_cs, s_we, irq});
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.o_ack, s_cs} !== 3'd0) $display("FAIL post_reset_idle: got %h required 0", {bus.o_ack, s_cs});
    else n_pass++;
  endtask

  task automatic test_read_slave1();
    int a; logic e; logic [15:0] d; logic [63:0] cs; logic [31:0] we; logic aa;
    run_txn(16'h0100, 1'b0, 16'h1234, 1, 3, 16'hBEEF, 1'b1, a, e, d, cs, we, aa);
    n_checks++; if (a !== 4) $display("FAIL read_ack_cycle: got %0d required 4", a); else n_pass++;
    n_checks++; if (e !== 1'b0) $display("FAIL read_err: got %b required 0", e); else n_pass++;
    n_checks++; if (d !== 16'hBEEF) $display("FAIL read_data: got %h required beef", d); else n_pass++;
    n_checks++; if (cs !== 64'hA8) $display("FAIL read_cs_trace: got %h required a8", cs); else n_pass++;
    n_checks++; if (aa !== 1'b0) $display("FAIL read_single_ack: got %b required 0", aa); else n_pass++;
  endtask

  task automatic test_write_slave0();
    int a; logic e; logic [15:0] d; logic [63:0] cs; logic [31:0] we; logic aa;
    run_txn(16'hFFFF, 1'b1, 16'h0041, 0, 1, 16'h7777, 1'b0, a, e, d, cs, we, aa);
    n_checks++; if (a !== 2) $display("FAIL write_ack_cycle: got %0d required 2", a); else n_pass++;
    n_checks++; if (cs !== 64'h4) $display("FAIL write_cs_trace: got %h required 4", cs); else n_pass++;
    n_checks++; if (we !== 32'h2) $display("FAIL write_we_trace: got %h required 2", we); else n_pass++;
    n_checks++; if ({s_addr, s_dat} !== {16'hFFFF, 16'h0041})
      $display("FAIL write_passthru: got %h required ffff0041", {s_addr, s_dat}); else n_pass++;
  endtask

  task automatic test_unmapped();
    int a; logic e; logic [15:0] d; logic [63:0] cs; logic [31:0] we; logic aa;
    run_txn(16'h4000, 1'b1, 16'h0000, -1, 1, 16'h0000, 1'b1, a, e, d, cs, we, aa);
    n_checks++; if (a !== 1) $display("FAIL unmapped_ack_cycle: got %0d required 1", a); else n_pass++;
    n_checks++; if ({e, d} !== {1'b1, ERRV}) $display("FAIL unmapped_err_data: got %h required 1dead", {e, d}); else n_pass++;
    n_checks++; if ({cs, we} !== 96'd0) $display("FAIL unmapped_no_select: got %h required 0", {cs, we}); else n_pass++;
    n_checks++; if (bus.o_dat !== ERRV) $display("FAIL unmapped_data_hold: got %h required dead", bus.o_dat); else n_pass++;
  endtask

  task automatic test_timeout();
`ifdef DCPU_BUS_TIMEOUT_EN
    int a; logic e; logic [15:0] d; logic [63:0] cs; logic [31:0] we; logic aa;
    run_txn(16'h0100, 1'b0, 16'h0000, 1, 0, 16'h0000, 1'b1, a, e, d, cs, we, aa);
    n_checks++; if (a !== 9) $display("FAIL timeout_ack_cycle: got %0d required 9", a); else n_pass++;
    n_checks++; if ({e, d} !== {1'b1, ERRV}) $display("FAIL timeout_err_data: got %h required 1dead", {e, d}); else n_pass++;
    n_checks++; if (cs !== 64'h2AAA8) $display("FAIL timeout_cs_trace: got %h required 2aaa8", cs); else n_pass++;
    run_txn(16'h0100, 1'b0, 16'h0000, 1, 8, 16'h600D, 1'b0, a, e, d, cs, we, aa);
    n_checks++; if ({a[7:0], e, d} !== {8'd9, 1'b0, 16'h600D})
      $display("FAIL timeout_last_cycle_ack: got %h required 09_0_600d", {a[7:0], e, d}); else n_pass++;
`endif
  endtask

  task automatic test_abort();
    logic got;
    bus.i_addr = 16'h0100; bus.i_we = 1'b0; bus.i_cs = 1'b1; s_ack = '0;
    tick();
    n_checks++; if (s_cs !== 2'b10) $display("FAIL abort_select: got %b required 10", s_cs); else n_pass++;
    tick();
    bus.i_cs = 1'b0;
    tick();
    n_checks++; if (s_cs !== 2'b00) $display("FAIL abort_drop_cs: got %b required 00", s_cs); else n_pass++;
    got = bus.o_ack;
    repeat (4) begin tick(); got |= bus.o_ack; end
    n_checks++; if (got !== 1'b0) $display("FAIL abort_no_ack: got %b required 0", got); else n_pass++;
    bus.i_cs = 1'b1;
    tick();
    tick();
    bus.i_cs = 1'b0; s_ack = 2'b10; s_rdat = 32'h5A5A_0000;
    tick();
    s_ack = '0;
    n_checks++; if ({bus.o_ack, bus.o_err, bus.o_dat} !== {2'b10, 16'h5A5A})
      $display("FAIL abort_vs_ack: got %h required 25a5a", {bus.o_ack, bus.o_err, bus.o_dat}); else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.i_addr = 16'hFFFE; bus.i_we = 1'b0; bus.i_cs = 1'b1; s_ack = '0;
    tick();
    s_ack = 2'b01; s_rdat = 32'h1111_C0DE;
    tick();
    s_ack = '0;
    n_checks++; if ({bus.o_ack, bus.o_dat} !== {1'b1, 16'hC0DE})
      $display("FAIL b2b_first_ack: got %h required 1c0de", {bus.o_ack, bus.o_dat}); else n_pass++;
    tick();
    n_checks++; if ({bus.o_ack, s_cs} !== 3'd0) $display("FAIL b2b_done_idle: got %h required 0", {bus.o_ack, s_cs}); else n_pass++;
    tick();
    n_checks++; if (s_cs !== 2'b00) $display("FAIL b2b_idle_cycle: got %b required 00", s_cs); else n_pass++;
    tick();
    n_checks++; if (s_cs !== 2'b01) $display("FAIL b2b_restart: got %b required 01", s_cs); else n_pass++;
    bus.i_cs = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic got;
    int a; logic e; logic [15:0] d; logic [63:0] cs; logic [31:0] we; logic aa;
    s_irq = 2'b10;
    bus.i_addr = 16'h0100; bus.i_we = 1'b1; bus.i_cs = 1'b1; s_ack = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_ack, bus.o_err, bus.o_dat, s_cs, s_we, irq} !== 22'd0)
      $display("FAIL reset_mid_outputs: got %h required 0", {bus.o_ack, bus.o_err, bus.o_dat, s_cs, s_we, irq});
    else n_pass++;
    bus.i_cs = 1'b0; s_irq = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    got = 1'b0;
    repeat (4) begin tick(); got |= bus.o_ack; end
    n_checks++; if (got !== 1'b0) $display("FAIL reset_mid_no_ack: got %b required 0", got); else n_pass++;
    run_txn(16'h0100, 1'b0, 16'h0000, 1, 2, 16'h1357, 1'b0, a, e, d, cs, we, aa);
    n_checks++; if ({a[7:0], e, d} !== {8'd3, 1'b0, 16'h1357})
      $display("FAIL reset_mid_recover: got %h required 03_0_1357", {a[7:0], e, d}); else n_pass++;
  endtask

  task automatic test_irq();
    logic [1:0] v;
    s_irq = 2'b01;
    tick(); tick();
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_masked: got %b required 0", irq); else n_pass++;
    s_irq = 2'b10;
    #1;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_lag: got %b required 0", irq); else n_pass++;
    tick();
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_enabled: got %b required 1", irq); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      v = 2'($urandom);
      s_irq = v;
      tick();
      n_checks++; if (irq !== v[1]) $display("FAIL irq_random: in %b got %b required %b", v, irq, v[1]); else n_pass++;
    end
    s_irq = '0;
    tick();
  endtask

  task automatic test_random();
    int a, e_a, slot, k; logic e, e_e, we_i, aa; logic [15:0] d, e_d, addr, rd;
    logic [63:0] cs, e_cs; logic [31:0] we, e_we;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: addr = 16'hFFFE | 16'($urandom_range(0, 1));
        1: addr = 16'($urandom_range(0, 16'h3FFF));
        default: addr = 16'($urandom);
      endcase
      we_i = 1'($urandom);
      rd   = 16'($urandom);
      k    = TMO_EN ? int'($urandom_range(0, 10)) : int'($urandom_range(1, 6));
      model_txn(addr, we_i, k, rd, slot, e_a, e_e, e_d, e_cs, e_we);
      run_txn(addr, we_i, 16'($urandom), slot, k, rd, 1'($urandom), a, e, d, cs, we, aa);
      n_checks++; if (a !== e_a) $display("FAIL rnd%0d_ack_cycle addr=%h: got %0d required %0d", i, addr, a, e_a); else n_pass++;
      n_checks++; if ({e, d} !== {e_e, e_d}) $display("FAIL rnd%0d_err_data addr=%h: got %h required %h", i, addr, {e, d}, {e_e, e_d}); else n_pass++;
      n_checks++; if (cs !== e_cs) $display("FAIL rnd%0d_cs_trace addr=%h: got %h required %h", i, addr, cs, e_cs); else n_pass++;
      n_checks++; if (we !== e_we) $display("FAIL rnd%0d_we_trace addr=%h: got %h required %h", i, addr, we, e_we); else n_pass++;
      n_checks++; if (aa !== 1'b0) $display("FAIL rnd%0d_single_ack: got %b required 0", i, aa); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_read_slave1();
    test_write_slave0();
    test_unmapped();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_irq();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end required end");
    $fatal(1);
  end

endmodule
